// File: rtl/wb_regfile_if.sv
// Write-back / register-read bundle between the pipeline (master) and the
// register file (slave).
interface wb_regfile_if;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic [31:0] ALUResult_i;
  logic [31:0] Memdata_i;
  logic [4:0]  RDaddr_i;
  logic [4:0]  RS1addr_i;
  logic [4:0]  RS2addr_i;
  logic [31:0] RS1data_o;
  logic [31:0] RS2data_o;
  logic [31:0] WBdata_o;
  logic [31:0] WBcount_o;

  modport master (
    output RegWrite_i, MemtoReg_i, ALUResult_i, Memdata_i,
    output RDaddr_i, RS1addr_i, RS2addr_i,
    input  RS1data_o, RS2data_o, WBdata_o, WBcount_o
  );

  modport slave (
    input  RegWrite_i, MemtoReg_i, ALUResult_i, Memdata_i,
    input  RDaddr_i, RS1addr_i, RS2addr_i,
    output RS1data_o, RS2data_o, WBdata_o, WBcount_o
  );
endinterface

// File: rtl/wb_regfile.sv
// 32 x 32-bit register file with write-back mux, optional write-to-read bypass
// and a counter of committed writes.
module wb_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_regfile_if.slave wb
);

  logic [31:0] regs_q [32];
  logic [31:0] wbcount_q;
  logic [31:0] wb_data;
  logic        commit;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  assign wb_data = wb.MemtoReg_i ? wb.Memdata_i : wb.ALUResult_i;
  assign commit  = wb.RegWrite_i && (wb.RDaddr_i != 5'd0);

  // NOTE: the array must be real flops, not RAM, because reset clears every
  // entry asynchronously; all sequential state uses non-blocking assignment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wbcount_q <= '0;
    end else if (commit) begin
      regs_q[wb.RDaddr_i] <= wb_data;
      wbcount_q           <= wbcount_q + 32'd1;
    end
  end

  // NOTE: defaults assigned first so no path leaves the outputs unassigned.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (wb.RS1addr_i != 5'd0) begin
      rs1_data = (BYPASS && commit && (wb.RS1addr_i == wb.RDaddr_i))
                 ? wb_data : regs_q[wb.RS1addr_i];
    end
    if (wb.RS2addr_i != 5'd0) begin
      rs2_data = (BYPASS && commit && (wb.RS2addr_i == wb.RDaddr_i))
                 ? wb_data : regs_q[wb.RS2addr_i];
    end
  end

  assign wb.RS1data_o = rs1_data;
  assign wb.RS2data_o = rs2_data;
  assign wb.WBdata_o  = wb_data;
  assign wb.WBcount_o = wbcount_q;

endmodule
